// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit that owns the architectural HI/LO registers.
// The result is computed at issue, held in pending registers, and committed after a fixed busy window.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   hi_nxt, lo_nxt;
    logic [31:0]   pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic          pend_dz, pend_dz_nxt;
    logic          issue;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, dsr_u, dsr_m;
    logic [31:0] q_u, r_u, q_mag, r_mag, q_s, r_s;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide goes through magnitudes, so 0x80000000 / -1 yields 0x80000000 rem 0.
    // A zero divisor is replaced by 1 only to keep the datapath defined; the result is discarded.
    assign a_mag = a[31] ? -a : a;
    assign b_mag = b[31] ? -b : b;
    assign dsr_u = (b == 32'd0) ? 32'd1 : b;
    assign dsr_m = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_u   = a / dsr_u;
    assign r_u   = a % dsr_u;
    assign q_mag = a_mag / dsr_m;
    assign r_mag = a_mag % dsr_m;
    assign q_s   = (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign r_s   = a[31] ? -r_mag : r_mag;

    assign busy  = (state == RUN);
    assign issue = start & ~req & (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_dz <= pend_dz_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_dz_nxt = pend_dz;
        case (state)
            IDLE: begin
                if (issue) begin
                    case (md_op)
                        3'd1: begin
                            {pend_hi_nxt, pend_lo_nxt} = prod_s;
                            pend_dz_nxt = 1'b0;
                            cnt_nxt     = CW'(MULT_CYCLES);
                            state_nxt   = RUN;
                        end
                        3'd2: begin
                            {pend_hi_nxt, pend_lo_nxt} = prod_u;
                            pend_dz_nxt = 1'b0;
                            cnt_nxt     = CW'(MULT_CYCLES);
                            state_nxt   = RUN;
                        end
                        3'd3: begin
                            pend_hi_nxt = r_s;
                            pend_lo_nxt = q_s;
                            pend_dz_nxt = (b == 32'd0);
                            cnt_nxt     = CW'(DIV_CYCLES);
                            state_nxt   = RUN;
                        end
                        3'd4: begin
                            pend_hi_nxt = r_u;
                            pend_lo_nxt = q_u;
                            pend_dz_nxt = (b == 32'd0);
                            cnt_nxt     = CW'(DIV_CYCLES);
                            state_nxt   = RUN;
                        end
                        3'd5:    hi_nxt = a;
                        3'd6:    lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    if (!pend_dz) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
